// File: rtl/ttfn_sweep_unit.sv
// Truth-table function unit: direct tt[in_vec] lookup with a valid/ready output register,
// plus an optional full-table sweep engine enabled by the TTFN_SWEEP_EN macro.
`timescale 1ns/1ps
module ttfn_sweep_unit #(
  parameter int unsigned              N_IN    = 4,
  parameter logic [(1<<N_IN)-1:0]     TT_INIT = 16'hB744
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN-1:0]       in_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic [N_IN-1:0]       out_idx,
  input  logic                  tt_load,
  input  logic [(1<<N_IN)-1:0]  tt_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [N_IN:0]         ones_cnt
);

  logic [(1<<N_IN)-1:0] tt;
  logic                 free;
  logic                 accept;
  logic                 tt_wr;
  logic                 sweep_ld;
  logic [N_IN-1:0]      sweep_idx;

  assign free   = !out_valid || out_ready;
  assign accept = in_valid && in_ready;

`ifdef TTFN_SWEEP_EN
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t state, state_nxt;
  logic   last_ld;
  logic   drain_hs;

  assign in_ready  = !rst && free && (state == IDLE) && !start;
  assign busy      = (state != IDLE);
  assign tt_wr     = tt_load && (state == IDLE);
  assign sweep_ld  = (state == SWEEP) && free;
  assign last_ld   = sweep_ld && (sweep_idx == '1);
  assign drain_hs  = (state == DRAIN) && out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = SWEEP;
      SWEEP:   if (last_ld)  state_nxt = DRAIN;
      DRAIN:   if (drain_hs) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // done is registered so it rises on the same edge that drops busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_idx <= '0;
      ones_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      done <= drain_hs;
      if ((state == IDLE) && start) begin
        sweep_idx <= '0;
        ones_cnt  <= '0;
      end else if (sweep_ld) begin
        sweep_idx <= sweep_idx + N_IN'(1);
        if (tt[sweep_idx]) ones_cnt <= ones_cnt + (N_IN+1)'(1);
      end
    end
  end
`else
  logic unused_start;

  assign unused_start = start;
  assign in_ready     = !rst && free;
  assign busy         = 1'b0;
  assign done         = 1'b0;
  assign ones_cnt     = '0;
  assign tt_wr        = tt_load;
  assign sweep_ld     = 1'b0;
  assign sweep_idx    = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        tt <= TT_INIT;
    else if (tt_wr) tt <= tt_data;
  end

  // accept and sweep_ld are mutually exclusive: in_ready is low outside IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_idx   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_bit   <= tt[in_vec];
      out_idx   <= in_vec;
    end else if (sweep_ld) begin
      out_valid <= 1'b1;
      out_bit   <= tt[sweep_idx];
      out_idx   <= sweep_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ttfn_sweep_unit.sv
// Self-checking bench for ttfn_sweep_unit: vector table, stall/throughput sequences and,
// when TTFN_SWEEP_EN is defined, sweep/reset corner cases, all checked through a scoreboard.
`timescale 1ns/1ps
module tb_ttfn_sweep_unit;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic         out_bit;
  logic [N-1:0] out_idx;
  logic         tt_load;
  logic [15:0]  tt_data;
  logic         start;
  logic         busy;
  logic         done;
  logic [N:0]   ones_cnt;

  ttfn_sweep_unit #(.N_IN(N), .TT_INIT(16'hB744)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_idx(out_idx),
    .tt_load(tt_load), .tt_data(tt_data), .start(start), .busy(busy), .done(done),
    .ones_cnt(ones_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] idx;
    logic         bit_v;
  } res_t;

  typedef struct {
    logic [N-1:0] vec;
    logic         exp_bit;
  } vec_t;

  res_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [15:0] model_tt = 16'hB744;
  vec_t        vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accepted vectors, pop on completed output handshakes
  always @(negedge clk) begin : mon
    res_t e;
    if (!rst) begin
      if (in_valid && in_ready) sb.push_back(res_t'({in_vec, model_tt[in_vec]}));
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got idx %0h bit %0b, expected no result", out_idx, out_bit);
        end else begin
          e = sb.pop_front();
          check("result_idx", 32'(out_idx), 32'(e.idx));
          check("result_bit", 32'(out_bit), 32'(e.bit_v));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_tt(input logic [15:0] d);
    tt_load = 1'b1;
    tt_data = d;
    cyc();
    tt_load  = 1'b0;
    model_tt = d;
  endtask

`ifdef TTFN_SWEEP_EN
  task automatic sweep(input bit bp, input bit poke);
    int exp_ones;
    int t;
    exp_ones = 0;
    done_cnt = 0;
    check("sweep_sb_empty", 32'(sb.size()), 0);
    for (int k = 0; k < 16; k++) begin
      sb.push_back(res_t'({4'(k), model_tt[k]}));
      exp_ones += int'(model_tt[k]);
    end
    start    = 1'b1;
    in_valid = 1'b1;
    in_vec   = 4'h3;
    check("start_blocks_in_ready", 32'(in_ready), 0);
    cyc();
    start    = 1'b0;
    in_valid = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    t = 0;
    while (!done && t < 200) begin
      if (bp) out_ready = ($urandom_range(0, 3) != 0);
      if (poke) begin
        tt_load = (t == 5);
        tt_data = 16'h0001;
      end
      cyc();
      t++;
    end
    tt_load   = 1'b0;
    out_ready = 1'b1;
    check("sweep_done_seen", 32'(done), 1);
    check("busy_falls_with_done", 32'(busy), 0);
    check("ones_cnt", 32'(ones_cnt), 32'(exp_ones));
    cyc();
    check("done_one_cycle", 32'(done), 0);
    cyc();
    check("done_pulse_count", 32'(done_cnt), 1);
    check("ones_cnt_held", 32'(ones_cnt), 32'(exp_ones));
    check("sweep_all_results", 32'(sb.size()), 0);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    tt_load   = 1'b0;
    tt_data   = '0;
    start     = 1'b0;

    vt[0] = '{4'h0, 1'b0};
    vt[1] = '{4'h2, 1'b1};
    vt[2] = '{4'h6, 1'b1};
    vt[3] = '{4'h7, 1'b0};
    vt[4] = '{4'h8, 1'b1};
    vt[5] = '{4'hB, 1'b0};
    vt[6] = '{4'hD, 1'b1};
    vt[7] = '{4'hF, 1'b1};

    repeat (2) cyc();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_out_bit", 32'(out_bit), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ones_cnt", 32'(ones_cnt), 0);
    rst = 1'b0;
    cyc();
    check("idle_in_ready", 32'(in_ready), 1);

    // Default-table vectors, back to back
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_vec   = vt[i].vec;
      cyc();
      check("vec_out_valid", 32'(out_valid), 1);
      check("vec_out_idx", 32'(out_idx), 32'(vt[i].vec));
      check("vec_out_bit", 32'(out_bit), 32'(vt[i].exp_bit));
    end
    in_valid = 1'b0;
    cyc();

    // Back-pressure: result held for three cycles, then full throughput
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 4'h5;
    cyc();
    in_vec = 4'h9;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_out_idx", 32'(out_idx), 5);
      check("stall_out_bit", 32'(out_bit), 0);
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_vec = (i == 0) ? 4'h9 : (i == 1) ? 4'hA : (i == 2) ? 4'hC : 4'hE;
      cyc();
      check("stream_out_valid", 32'(out_valid), 1);
      check("stream_out_idx", 32'(out_idx), 32'(in_vec));
    end
    in_valid = 1'b0;
    cyc();

    // Table reload
    load_tt(16'h8000);
    in_valid = 1'b1;
    in_vec   = 4'hF;
    cyc();
    check("tt8000_f", 32'(out_bit), 1);
    in_vec = 4'hE;
    cyc();
    check("tt8000_e", 32'(out_bit), 0);

    // Held result then asynchronous reset mid-cycle; table returns to TT_INIT
    out_ready = 1'b0;
    in_vec    = 4'hF;
    cyc();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_out_idx", 32'(out_idx), 0);
    check("async_rst_out_bit", 32'(out_bit), 0);
    check("async_rst_in_ready", 32'(in_ready), 0);
    sb.delete();
    model_tt  = 16'hB744;
    out_ready = 1'b1;
    cyc();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_vec   = 4'h2;
    cyc();
    check("tt_restored_by_rst", 32'(out_bit), 1);
    in_valid = 1'b0;
    cyc();

`ifdef TTFN_SWEEP_EN
    sweep(1'b0, 1'b0);
    sweep(1'b1, 1'b1);
    in_valid = 1'b1;
    in_vec   = 4'h0;
    cyc();
    check("tt_unchanged_by_sweep_load", 32'(out_bit), 0);
    in_valid = 1'b0;
    cyc();

    // Reset at sweep index 7, then a complete fresh sweep
    for (int k = 0; k < 16; k++) sb.push_back(res_t'({4'(k), model_tt[k]}));
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int t = 0; t < 40 && !(out_valid && out_idx == 4'h7); t++) cyc();
    check("reach_idx7", 32'(out_idx), 7);
    #2;
    rst = 1'b1;
    #1;
    check("midsweep_rst_busy", 32'(busy), 0);
    check("midsweep_rst_out_valid", 32'(out_valid), 0);
    check("midsweep_rst_out_idx", 32'(out_idx), 0);
    check("midsweep_rst_ones_cnt", 32'(ones_cnt), 0);
    check("midsweep_rst_done", 32'(done), 0);
    check("midsweep_rst_in_ready", 32'(in_ready), 0);
    sb.delete();
    cyc();
    rst = 1'b0;
    cyc();
    check("post_rst_in_ready", 32'(in_ready), 1);
    sweep(1'b0, 1'b0);
`else
    start    = 1'b1;
    in_valid = 1'b1;
    in_vec   = 4'h2;
    check("nosweep_in_ready", 32'(in_ready), 1);
    cyc();
    start    = 1'b0;
    in_valid = 1'b0;
    check("nosweep_busy", 32'(busy), 0);
    check("nosweep_done", 32'(done), 0);
    check("nosweep_ones_cnt", 32'(ones_cnt), 0);
    check("nosweep_out_idx", 32'(out_idx), 2);
    check("nosweep_out_bit", 32'(out_bit), 1);
    cyc();
`endif

    repeat (2) cyc();
    check("final_sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ttfn_sweep_unit.md
TTFN_SWEEP_UNIT -- requirements
Module: ttfn_sweep_unit

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning the number of logic inputs (1..8).
REQ-002 SHALL have parameter TT_INIT, default 16'hB744, width 2**N_IN, meaning the truth table loaded at reset.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  input vector offered.
REQ-006 SHALL have port in_ready  output  1  input vector accepted when in_valid is also high.
REQ-007 SHALL have port in_vec  input  N_IN  input vector; bit i is logic input i.
REQ-008 SHALL have port out_valid  output  1  result held in the output register.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_bit  output  1  function value.
REQ-011 SHALL have port out_idx  output  N_IN  input vector that produced out_bit.
REQ-012 SHALL have port tt_load  input  1  one-cycle strobe that replaces the table.
REQ-013 SHALL have port tt_data  input  2**N_IN  new table value.
REQ-014 SHALL have port start  input  1  sweep request.
REQ-015 SHALL have port busy  output  1  sweep in progress.
REQ-016 SHALL have port done  output  1  one-cycle sweep-complete pulse.
REQ-017 SHALL have port ones_cnt  output  N_IN+1  number of 1 results in the last sweep.

Function
REQ-018 SHALL compute the function value as tt[in_vec], where tt is the internal table register and bit k of tt is the output for vector value k.
REQ-019 SHALL drive in_ready = (!out_valid || out_ready) && state==IDLE && !start.
REQ-020 SHALL register the accepted vector and its result into out_idx/out_bit and set out_valid on the next edge; latency is 1 cycle.
REQ-021 SHALL hold out_bit and out_idx stable while out_valid && !out_ready.
REQ-022 SHALL give full throughput: one result per cycle while out_ready stays high.
REQ-023 SHALL write tt_data into tt on tt_load in IDLE; a vector accepted in the same cycle SHALL use the old table.
REQ-024 SHALL ignore tt_load while busy.
REQ-025 SHALL run an FSM with states IDLE, SWEEP and DRAIN.
REQ-026 SHALL go IDLE->SWEEP on start when in IDLE, clearing the sweep index and ones_cnt to 0.
REQ-027 SHALL, in SWEEP, load the output register with (index, tt[index]) whenever the register is free (!out_valid || out_ready), then increment the index.
REQ-028 SHALL go SWEEP->DRAIN when index 2**N_IN-1 is loaded.
REQ-029 SHALL go DRAIN->IDLE when the last result completes its handshake, and SHALL pulse done high for exactly that cycle.
REQ-030 SHALL increment ones_cnt for each sweep result with out_bit=1 at load time; ones_cnt SHALL hold its value until the next start and SHALL NOT wrap (maximum 2**N_IN fits in N_IN+1 bits).
REQ-031 SHALL drive busy high in SWEEP and DRAIN.
REQ-032 SHALL ignore start while busy.
REQ-033 SHALL NOT let a sweep change tt; results SHALL use the table as it was at start.

Reset
REQ-034 SHALL, on rst (asynchronous and immediate, including mid-sweep), set tt=TT_INIT, state=IDLE, out_valid=0, out_bit=0, out_idx=0, busy=0, done=0, ones_cnt=0, and index=0.
REQ-035 SHALL drive in_ready=0 while rst is high; after release, in_ready follows REQ-019.

Configuration
REQ-036 SHALL provide macro TTFN_SWEEP_EN; when it is defined, the FSM, index counter, ones_cnt, busy and done exist as specified.
REQ-037 SHALL, when TTFN_SWEEP_EN is undefined, ignore start and tie busy=0, done=0 and ones_cnt=0; state is permanently IDLE and the direct path is unchanged.

Verification
REQ-038 SHALL cover: default table, in_vec=4'h0 -> out_bit=0, out_idx=0 one cycle later; in_vec=4'h2 -> out_bit=1.
REQ-039 SHALL cover: out_ready low 3 cycles with in_valid high -> in_ready=0 and out_idx/out_bit held; then 1 result per cycle.
REQ-040 SHALL cover: start on the default table, out_ready=1 -> 16 results with idx 0..15 in order, ones_cnt=8, done pulses once, busy falls the same cycle.
REQ-041 SHALL cover: tt_load with tt_data=16'h8000, then in_vec=4'hF -> out_bit=1 and in_vec=4'hE -> 0; tt_load during a sweep -> table unchanged.
REQ-042 SHALL cover: rst asserted at sweep index 7 -> all outputs at reset values immediately; a new start gives a full 16-result sweep.
REQ-043 SHALL cover: start and in_valid in the same cycle -> vector not accepted and the sweep begins.
